// File: rtl/shift_seq_detector_pkg.sv
// Shared constants for the serial sequence detector: match-mode encodings and slot-select sizing.
package shift_seq_detector_pkg;

    localparam logic MODE_OVL = 1'b0;
    localparam logic MODE_NOV = 1'b1;

    function automatic int sel_w(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/seq_slot_cmp.sv
// One pattern slot: code/mask registers, masked compare against the next history value,
// availability counter gating (non-)overlap matching, and a saturating hit counter.
module seq_slot_cmp
    import shift_seq_detector_pkg::*;
#(
    parameter int N   = 4,
    parameter int CW  = 8,
    parameter int SW  = 1,
    parameter int IDX = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept,
    input  logic          fill_full,
    input  logic          hist_load,
    input  logic [N-1:0]  sh_nx,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_sel,
    input  logic [N-1:0]  cfg_code,
    input  logic [N-1:0]  cfg_mask,
    input  logic          mode_nov,
    input  logic          cnt_clr,
    output logic          match,
    output logic [CW-1:0] cnt
);
    localparam int AW = $clog2(N + 1);
    localparam logic [SW-1:0] MY_SEL = SW'(IDX);
    localparam logic [AW-1:0] FULL   = AW'(N);

    logic [N-1:0]  code_q;
    logic [N-1:0]  mask_q;
    logic [AW-1:0] avail;
    logic [AW-1:0] avail_nx;
    logic          hit;
    logic          sel_me;

    assign sel_me = cfg_we && (cfg_sel == MY_SEL);

    always_comb begin
        avail_nx = avail;
        if (accept && avail != FULL)
            avail_nx = avail + 1'b1;
    end

    // Compare uses the registered code/mask, so a same-cycle write only affects later bits.
    assign hit = accept && (|mask_q) && fill_full && (avail_nx == FULL)
                 && (((sh_nx ^ code_q) & mask_q) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            mask_q <= '0;
            avail  <= '0;
            match  <= 1'b0;
            cnt    <= '0;
        end else begin
            if (sel_me) begin
                code_q <= cfg_code;
                mask_q <= cfg_mask;
            end
            match <= hit;
            if (hist_load)
                avail <= FULL;
            else if (hit && mode_nov == MODE_NOV)
                avail <= '0;
            else
                avail <= avail_nx;
            if (cnt_clr)
                cnt <= '0;
            else if (hit && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_seq_detector.sv
// Serial multi-pattern detector top: history shift register with preload and fill tracking,
// fanned out to P independent compare slots.
module shift_seq_detector
    import shift_seq_detector_pkg::*;
#(
    parameter int N  = 4,
    parameter int P  = 2,
    parameter int CW = 8,
    localparam int SW = sel_w(P)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_bit,
    input  logic            in_valid,
    input  logic            hist_load,
    input  logic [N-1:0]    hist_data,
    input  logic            cfg_we,
    input  logic [SW-1:0]   cfg_sel,
    input  logic [N-1:0]    cfg_code,
    input  logic [N-1:0]    cfg_mask,
    input  logic            mode_nov,
    input  logic            cnt_clr,
    output logic [N-1:0]    shift_q,
    output logic [P-1:0]    match,
    output logic            any_match,
    output logic [P*CW-1:0] match_cnt
);
    localparam int AW = $clog2(N + 1);
    localparam logic [AW-1:0] FULL = AW'(N);

    logic [AW-1:0] fill;
    logic [AW-1:0] fill_nx;
    logic [N-1:0]  sh_nx;
    logic          accept;
    logic          fill_full;

    // Preload wins over a same-cycle serial bit.
    assign accept    = in_valid && !hist_load;
    assign sh_nx     = {shift_q[N-2:0], in_bit};
    assign fill_nx   = (fill == FULL) ? FULL : fill + 1'b1;
    assign fill_full = (fill_nx == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            fill    <= '0;
        end else if (hist_load) begin
            shift_q <= hist_data;
            fill    <= FULL;
        end else if (accept) begin
            shift_q <= sh_nx;
            fill    <= fill_nx;
        end
    end

    for (genvar i = 0; i < P; i++) begin : g_slot
        seq_slot_cmp #(.N(N), .CW(CW), .SW(SW), .IDX(i)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .accept    (accept),
            .fill_full (fill_full),
            .hist_load (hist_load),
            .sh_nx     (sh_nx),
            .cfg_we    (cfg_we),
            .cfg_sel   (cfg_sel),
            .cfg_code  (cfg_code),
            .cfg_mask  (cfg_mask),
            .mode_nov  (mode_nov),
            .cnt_clr   (cnt_clr),
            .match     (match[i]),
            .cnt       (match_cnt[i*CW +: CW])
        );
    end

    assign any_match = |match;

endmodule

// File: tb/tb_shift_seq_detector.sv
// Self-checking bench: two detectors (CW=8 and CW=2) share one stimulus stream; expected
// per-cycle outputs go through a scoreboard queue and are compared one cycle later.
module tb_shift_seq_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_bit, in_valid, hist_load, cfg_we, mode_nov, cnt_clr;
    logic [3:0]  hist_data, cfg_code, cfg_mask;
    logic [0:0]  cfg_sel;
    logic [3:0]  shift_q, shift_q2;
    logic [1:0]  match, match2;
    logic        any_match, any_match2;
    logic [15:0] match_cnt;
    logic [3:0]  match_cnt2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      nm;
        logic [1:0] m;
        logic [3:0] sh;
        bit         csh;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       b;
        logic [1:0] m;
        logic [3:0] sh;
    } vec_t;
    vec_t t1[9];

    always #5 clk = ~clk;

    shift_seq_detector #(.N(4), .P(2), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .hist_load(hist_load), .hist_data(hist_data), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_code(cfg_code), .cfg_mask(cfg_mask), .mode_nov(mode_nov), .cnt_clr(cnt_clr),
        .shift_q(shift_q), .match(match), .any_match(any_match), .match_cnt(match_cnt)
    );

    shift_seq_detector #(.N(4), .P(2), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .hist_load(hist_load), .hist_data(hist_data), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_code(cfg_code), .cfg_mask(cfg_mask), .mode_nov(mode_nov), .cnt_clr(cnt_clr),
        .shift_q(shift_q2), .match(match2), .any_match(any_match2), .match_cnt(match_cnt2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input string nm, input logic [1:0] m, input logic [3:0] sh, input bit csh);
        exp_t e;
        sb.push_back('{nm, m, sh, csh});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.nm, " match"}, int'(match), int'(e.m));
        chk({e.nm, " any_match"}, int'(any_match), int'(|e.m));
        chk({e.nm, " match_cw2"}, int'(match2), int'(e.m));
        if (e.csh) chk({e.nm, " shift_q"}, int'(shift_q), int'(e.sh));
    endtask

    task automatic idle();
        in_valid = 1'b0; hist_load = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        idle();
        rst = 1'b1;
        tick({nm, " reset"}, 2'b00, 4'h0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [0:0] sel, input logic [3:0] code, input logic [3:0] mask);
        idle();
        cfg_we = 1'b1; cfg_sel = sel; cfg_code = code; cfg_mask = mask;
        tick("cfg", 2'b00, 4'h0, 1'b0);
        cfg_we = 1'b0;
    endtask

    // Bits applied LSB first; m0/m1 give expected match pulses per accepted bit.
    task automatic stream(input string nm, input int n, input logic [31:0] bv,
                          input logic [31:0] m0, input logic [31:0] m1);
        for (int i = 0; i < n; i++) begin
            idle();
            in_bit = bv[i]; in_valid = 1'b1;
            tick($sformatf("%s[%0d]", nm, i), {m1[i], m0[i]}, 4'h0, 1'b0);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t1[0] = '{1'b1, 2'b00, 4'h1};
        t1[1] = '{1'b1, 2'b00, 4'h3};
        t1[2] = '{1'b0, 2'b00, 4'h6};
        t1[3] = '{1'b1, 2'b00, 4'hD};
        t1[4] = '{1'b1, 2'b00, 4'hB};
        t1[5] = '{1'b0, 2'b01, 4'h6};
        t1[6] = '{1'b1, 2'b00, 4'hD};
        t1[7] = '{1'b0, 2'b00, 4'hA};
        t1[8] = '{1'b1, 2'b00, 4'h5};

        rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; hist_load = 1'b0; hist_data = '0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_code = '0; cfg_mask = '0; mode_nov = 1'b0;
        cnt_clr = 1'b0;

        do_reset("init");
        chk("reset cnt", int'(match_cnt), 0);
        chk("reset cnt_cw2", int'(match_cnt2), 0);

        // 0110 pattern, overlap, table-driven
        cfg(1'b0, 4'h6, 4'hF);
        for (int i = 0; i < 9; i++) begin
            idle();
            in_bit = t1[i].b; in_valid = 1'b1;
            tick($sformatf("t1[%0d]", i), t1[i].m, t1[i].sh, 1'b1);
        end
        idle();
        chk("t1 cnt0", int'(match_cnt[7:0]), 1);
        chk("t1 cnt1", int'(match_cnt[15:8]), 0);

        // all-ones, overlap: hits on bits 4..8; CW=2 counter saturates at 3
        do_reset("t2o");
        cfg(1'b0, 4'hF, 4'hF);
        mode_nov = 1'b0;
        stream("t2o", 8, 32'hFF, 32'hF8, 32'h0);
        chk("t2o cnt0", int'(match_cnt[7:0]), 5);
        chk("t2o cnt0_cw2", int'(match_cnt2[1:0]), 3);

        // all-ones, non-overlap: hits on bits 4 and 8
        do_reset("t2n");
        cfg(1'b0, 4'hF, 4'hF);
        mode_nov = 1'b1;
        stream("t2n", 8, 32'hFF, 32'h88, 32'h0);
        chk("t2n cnt0", int'(match_cnt[7:0]), 2);
        mode_nov = 1'b0;

        // masked slot1: 1,0,1,1 then 1,1,0,1
        do_reset("t3");
        cfg(1'b1, 4'b1001, 4'b1001);
        stream("t3", 8, 32'b1011_1101, 32'h0, 32'b1010_1000);
        chk("t3 cnt1", int'(match_cnt[15:8]), 3);
        chk("t3 cnt0", int'(match_cnt[7:0]), 0);

        // preload with a coincident serial bit: bit dropped
        do_reset("t4");
        cfg(1'b0, 4'h5, 4'hF);
        idle();
        hist_load = 1'b1; hist_data = 4'hA; in_valid = 1'b1; in_bit = 1'b1;
        tick("t4 preload", 2'b00, 4'hA, 1'b1);
        idle();
        in_valid = 1'b1; in_bit = 1'b1;
        tick("t4 bit", 2'b01, 4'h5, 1'b1);
        idle();

        // cnt_clr coincident with a hit, then cfg_we coincident with completing bit
        do_reset("t5");
        cfg(1'b0, 4'hF, 4'hF);
        stream("t5", 4, 32'hF, 32'h8, 32'h0);
        idle();
        in_valid = 1'b1; in_bit = 1'b1; cnt_clr = 1'b1;
        tick("t5 clr", 2'b01, 4'hF, 1'b1);
        chk("t5 clr cnt0", int'(match_cnt[7:0]), 0);
        chk("t5 clr cnt0_cw2", int'(match_cnt2[1:0]), 0);
        idle();
        in_valid = 1'b1; in_bit = 1'b1;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_code = 4'h0; cfg_mask = 4'hF;
        tick("t5 cfgold", 2'b01, 4'hF, 1'b1);
        idle();
        stream("t5new", 5, 32'b00001, 32'b10000, 32'h0);
        chk("t5 cnt0", int'(match_cnt[7:0]), 2);
        chk("t5 cnt0_cw2", int'(match_cnt2[1:0]), 2);

        // reset mid-pattern discards history and config
        do_reset("t6");
        cfg(1'b0, 4'hF, 4'hF);
        stream("t6pre", 3, 32'h7, 32'h0, 32'h0);
        idle();
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        tick("t6 rst", 2'b00, 4'h0, 1'b1);
        idle();
        stream("t6post", 5, 32'h1F, 32'h0, 32'h0);
        chk("t6 cnt0", int'(match_cnt[7:0]), 0);
        cfg(1'b0, 4'hF, 4'hF);
        idle();
        in_valid = 1'b1; in_bit = 1'b1;
        tick("t6 reprog", 2'b01, 4'hF, 1'b1);
        idle();
        chk("t6 cnt0 final", int'(match_cnt[7:0]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
